reg_bank_param: RTL

//  Parametrised two-read/one-write register bank, the successor of the fixed 16x64 bank.

---
 rtl/reg_bank_pkg.sv | 18 +
 rtl/reg_bank_wmerge.sv | 27 ++
 rtl/reg_bank_param.sv | 96 +++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types for the parametrised register bank: write-mode encoding and clear-engine states.
// Pure type definitions. No latency and no backpressure apply here.
// Imported by reg_bank_wmerge and reg_bank_param.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        WM_FULL = 2'b00,
        WM_LO   = 2'b01,
        WM_HI   = 2'b10,
        WM_SEXT = 2'b11
    } wmode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/reg_bank_wmerge.sv
// Partial-word merge. Combines the old register contents with new write data according to the write mode.
// Combinational, so latency is 0. There is no backpressure.
// The write path and the forwarding path share this merge.
module reg_bank_wmerge
    import reg_bank_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] i_old,
    input  logic [W-1:0] i_new,
    input  wmode_t       i_mode,
    output logic [W-1:0] o_merged
);

    localparam int H = W / 2;

    always_comb begin
        o_merged = i_new;
        case (i_mode)
            WM_FULL: o_merged = i_new;
            WM_LO:   o_merged = {i_old[W-1:H], i_new[H-1:0]};
            WM_HI:   o_merged = {i_new[W-1:H], i_old[H-1:0]};
            default: o_merged = {{H{i_new[H-1]}}, i_new[H-1:0]};
        endcase
    end

endmodule

// File: rtl/reg_bank_param.sv
// Two-read/one-write register bank with partial-word writes, an optional zero register and a bulk-clear engine.
// Reads take 1 cycle through registered outA/outB. A clear holds busy for DEPTH cycles.
// Writes that arrive during a clear are dropped and reported on wr_drop. REG_BANK_BYPASS_EN adds same-cycle forwarding.
module reg_bank_param
    import reg_bank_pkg::*;
#(
    parameter int           W       = 64,
    parameter int           DEPTH   = 16,
    parameter logic [W-1:0] CONST_A = '0,
    parameter logic [W-1:0] CONST_B = W'(1),
    parameter bit           ZERO_R0 = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     regwen,
    input  logic [W-1:0]             inA,
    input  logic [$clog2(DEPTH)-1:0] selwreg,
    input  logic [1:0]               endwreg,
    input  logic [$clog2(DEPTH)-1:0] seloutA,
    input  logic [$clog2(DEPTH)-1:0] seloutB,
    input  logic                     cnstA,
    input  logic                     cnstB,
    input  logic                     enrregA,
    input  logic                     enrregB,
    input  logic                     clr_start,
    output logic [W-1:0]             outA,
    output logic [W-1:0]             outB,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_regs [DEPTH];
    clr_state_t    r_state;
    logic [AW-1:0] r_ptr;
    logic          r_wr_drop;

    logic [W-1:0]  w_merged;
    logic [W-1:0]  w_rd_a;
    logic [W-1:0]  w_rd_b;
    logic          w_wr_ok;

    reg_bank_wmerge #(.W(W)) u_wmerge (
        .i_old    (r_regs[selwreg]),
        .i_new    (inA),
        .i_mode   (wmode_t'(endwreg)),
        .o_merged (w_merged)
    );

    // Register 0 is never written when hardwired, so it stays at its reset value of zero.
    assign w_wr_ok = regwen && (r_state == IDLE) && !(ZERO_R0 && (selwreg == '0));

`ifdef REG_BANK_BYPASS_EN
    assign w_rd_a = (w_wr_ok && (selwreg == seloutA)) ? w_merged : r_regs[seloutA];
    assign w_rd_b = (w_wr_ok && (selwreg == seloutB)) ? w_merged : r_regs[seloutB];
`else
    assign w_rd_a = r_regs[seloutA];
    assign w_rd_b = r_regs[seloutB];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_wr_drop <= 1'b0;
            outA      <= '0;
            outB      <= '0;
        end else begin
            r_wr_drop <= regwen && (r_state == CLEAR);
            if (enrregA) outA <= cnstA ? CONST_A : w_rd_a;
            if (enrregB) outB <= cnstB ? CONST_B : w_rd_b;
            case (r_state)
                IDLE: begin
                    if (w_wr_ok) r_regs[selwreg] <= w_merged;
                    if (clr_start) begin
                        r_state <= CLEAR;
                        r_ptr   <= '0;
                    end
                end
                default: begin
                    r_regs[r_ptr] <= '0;
                    r_ptr         <= r_ptr + AW'(1);
                    if (r_ptr == AW'(DEPTH - 1)) r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state == CLEAR);
    assign wr_drop = r_wr_drop;

endmodule
